spice_step_sched: RTL and testbench

- Time-multiplexed node-integration scheduler for the analog netlist simulator.
- Replaces per-node parallel integrators with one shared accumulate/commit datapath over a register file of N node voltages.
- Accepts a stream of (node, current) contributions for one timestep, then sequences the commit v[n] <= v[n] + sum(i) across all nodes.
- Provides a registered voltage readback port for the device models.

---
 rtl/spice_step_sched.sv | 106 ++++++++++
 tb/tb_spice_step_sched.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spice_step_sched.sv
// Time-multiplexed node-integration scheduler: accumulates per-node current contributions for a
// timestep, then sweeps one shared adder across the node register file to commit voltages.
module spice_step_sched #(
    parameter int unsigned W  = 16,
    parameter int unsigned N  = 16,
    parameter int unsigned AW = 4
) (
    input  logic                eclk,
    input  logic                ereset_n,
    input  logic                clr,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [AW-1:0]       in_node,
    input  logic signed [W-1:0] in_i,
    input  logic                in_last,
    input  logic [AW-1:0]       rd_addr,
    output logic signed [W-1:0] rd_v,
    output logic                busy,
    output logic                step_done,
    output logic [15:0]         step_count
);

    typedef enum logic [1:0] {StIdle, StAccum, StCommit} state_e;

    localparam logic [AW-1:0] LastNode = AW'(N - 1);
    localparam logic [AW-1:0] FirstNode = AW'(1);

    state_e              state_q;
    logic [AW-1:0]       ptr_q;
    logic signed [W-1:0] v_q   [N];
    logic signed [W-1:0] acc_q [N];

    logic in_hit;
    logic rd_hit;

    // Ground and out-of-range nodes never touch the register file.
    assign in_hit = (in_node != '0) && (int'(in_node) < int'(N));
    assign rd_hit = (rd_addr != '0) && (int'(rd_addr) < int'(N));

    // acc_q is read straight from the flops every cycle, so a beat always sees the sum written
    // by the beat on the previous edge; back-to-back hits on one node cannot lose an add.
    always_ff @(posedge eclk or negedge ereset_n) begin
        if (!ereset_n) begin
            state_q    <= StIdle;
            ptr_q      <= FirstNode;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            step_done  <= 1'b0;
            step_count <= '0;
            rd_v       <= '0;
            for (int n = 0; n < int'(N); n++) begin
                v_q[n]   <= '0;
                acc_q[n] <= '0;
            end
        end else begin
            step_done <= 1'b0;
            rd_v      <= rd_hit ? v_q[rd_addr] : '0;

            unique case (state_q)
                StIdle: begin
                    if (clr) begin
                        for (int n = 0; n < int'(N); n++) begin
                            v_q[n]   <= '0;
                            acc_q[n] <= '0;
                        end
                    end
                    if (start) begin
                        state_q  <= StAccum;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end

                StAccum: begin
                    if (in_valid) begin
                        if (in_hit) begin
                            acc_q[in_node] <= acc_q[in_node] + in_i;
                        end
                        if (in_last) begin
                            state_q  <= StCommit;
                            in_ready <= 1'b0;
                            ptr_q    <= FirstNode;
                        end
                    end
                end

                StCommit: begin
                    v_q[ptr_q]   <= v_q[ptr_q] + acc_q[ptr_q];
                    acc_q[ptr_q] <= '0;
                    if (ptr_q == LastNode) begin
                        state_q    <= StIdle;
                        busy       <= 1'b0;
                        step_done  <= 1'b1;
                        step_count <= step_count + 16'd1;
                    end else begin
                        ptr_q <= ptr_q + FirstNode;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_spice_step_sched.sv
// Scoreboard bench for spice_step_sched: a voltage/accumulator model predicts every readback,
// plus latency, handshake and reset behaviour.
module tb_spice_step_sched;

    localparam int W = 16;
    localparam int N = 16;
    localparam int AW = 4;

    logic                eclk = 1'b0;
    logic                ereset_n = 1'b0;
    logic                clr = 1'b0;
    logic                start = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [AW-1:0]       in_node = '0;
    logic signed [W-1:0] in_i = '0;
    logic                in_last = 1'b0;
    logic [AW-1:0]       rd_addr = '0;
    logic signed [W-1:0] rd_v;
    logic                busy;
    logic                step_done;
    logic [15:0]         step_count;

    spice_step_sched #(.W(W), .N(N), .AW(AW)) dut (
        .eclk       (eclk),
        .ereset_n   (ereset_n),
        .clr        (clr),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_node    (in_node),
        .in_i       (in_i),
        .in_last    (in_last),
        .rd_addr    (rd_addr),
        .rd_v       (rd_v),
        .busy       (busy),
        .step_done  (step_done),
        .step_count (step_count)
    );

    always #5 eclk = ~eclk;

    typedef struct {
        int node;
        int cur;
    } beat_t;

    beat_t       beats[$];
    logic [15:0] exp_q[$];
    logic [15:0] mv   [N];
    logic [15:0] macc [N];
    logic [15:0] mcount;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < N; n++) begin
            mv[n]   = '0;
            macc[n] = '0;
        end
    endtask

    task automatic read_all();
        logic [15:0] got;
        for (int n = 0; n < N; n++) begin
            @(negedge eclk);
            rd_addr = AW'(n);
            exp_q.push_back((n == 0) ? 16'd0 : mv[n]);
            @(posedge eclk);
            #1;
            got = rd_v;
            check($sformatf("rd_v[%0d]", n), 32'(got), 32'(exp_q.pop_front()));
        end
    endtask

    // Runs one timestep from the beats queue; hold_commit keeps in_valid high through COMMIT
    // and pulses start mid-sweep.
    task automatic run_step(input bit hold_commit);
        int cyc;
        bit done;
        @(negedge eclk);
        start = 1'b1;
        @(negedge eclk);
        start = 1'b0;
        check("accum_ready", 32'(in_ready), 32'd1);
        check("accum_busy", 32'(busy), 32'd1);
        foreach (beats[k]) begin
            in_valid = 1'b1;
            in_node  = AW'(beats[k].node);
            in_i     = W'(beats[k].cur);
            in_last  = (k == beats.size() - 1);
            @(posedge eclk);
            if (beats[k].node != 0 && beats[k].node < N)
                macc[beats[k].node] = macc[beats[k].node] + 16'(beats[k].cur);
            #1;
        end
        in_valid = hold_commit;
        in_last  = 1'b0;
        in_node  = AW'(3);
        in_i     = 16'sd7;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 100) begin
            @(posedge eclk);
            cyc++;
            #1;
            if (hold_commit) begin
                check("commit_ready", 32'(in_ready), 32'd0);
                if (cyc == 5) start = 1'b1;
                if (cyc == 6) start = 1'b0;
            end
            done = step_done;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        check("done_latency", 32'(cyc), 32'(N - 1));
        for (int n = 1; n < N; n++) begin
            mv[n]   = mv[n] + macc[n];
            macc[n] = '0;
        end
        mcount = mcount + 16'd1;
        check("step_count", 32'(step_count), 32'(mcount));
        check("busy_after", 32'(busy), 32'd0);
        @(posedge eclk);
        #1;
        check("done_once", 32'(step_done), 32'd0);
        check("stay_idle", 32'(busy), 32'd0);
    endtask

    task automatic load_a();
        beats.delete();
        beats.push_back('{node: 3, cur: 5});
        beats.push_back('{node: 3, cur: -2});
        beats.push_back('{node: 7, cur: 100});
    endtask

    initial begin
        model_reset();
        mcount = '0;
        repeat (2) @(negedge eclk);
        check("rst_rd_v", 32'(rd_v), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(step_done), 32'd0);
        check("rst_count", 32'(step_count), 32'd0);
        ereset_n = 1'b1;

        load_a();
        run_step(1'b0);
        read_all();

        repeat (2) run_step(1'b0);
        read_all();

        beats.delete();
        beats.push_back('{node: 0, cur: 50});
        beats.push_back('{node: 15, cur: -1});
        run_step(1'b0);
        read_all();

        beats.delete();
        beats.push_back('{node: 5, cur: 32767});
        run_step(1'b0);
        beats.delete();
        beats.push_back('{node: 5, cur: 1});
        run_step(1'b0);
        read_all();

        // Contributions offered in IDLE must be refused.
        @(negedge eclk);
        in_valid = 1'b1;
        in_node  = AW'(3);
        in_i     = 16'sd7;
        repeat (3) begin
            @(negedge eclk);
            check("idle_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;

        load_a();
        run_step(1'b1);
        read_all();

        // Abort mid-COMMIT with the sweep pointer at node 8.
        @(negedge eclk);
        start = 1'b1;
        @(negedge eclk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_node  = AW'(4);
        in_i     = 16'sd11;
        in_last  = 1'b1;
        @(posedge eclk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (7) @(posedge eclk);
        #2;
        check("mid_busy", 32'(busy), 32'd1);
        ereset_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_count", 32'(step_count), 32'd0);
        check("arst_rd_v", 32'(rd_v), 32'd0);
        @(negedge eclk);
        ereset_n = 1'b1;
        model_reset();
        mcount = '0;
        read_all();

        load_a();
        run_step(1'b0);
        @(negedge eclk);
        clr = 1'b1;
        @(negedge eclk);
        clr = 1'b0;
        model_reset();
        read_all();

        // Accumulators must also have been cleared.
        load_a();
        run_step(1'b0);
        read_all();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
